tanh_series_unit: RTL and testbench

- Parametrised successor to the team's fixed 16-bit tanh calculator.
- Evaluates tanh(x), or sigmoid(x) selected by `mode`, on a signed fixed-point operand.
- Uses a Horner-form odd Taylor series with a configurable term count, saturation beyond a threshold and constant latency.
- Sits behind the same start/ready handshake used by the activation datapath; one shared multiplier, iterative controller.

---
 rtl/tanh_series_unit.sv | 101 ++++++++++
 tb/tb_tanh_series_unit.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/tanh_series_unit.sv
// tanh_series_unit: iterative Horner-series tanh/sigmoid on a signed Q operand, one shared multiplier
module tanh_series_unit #(
  parameter int W = 16,
  parameter int FRAC = 14,
  parameter int TERMS = 4,
  parameter int XSAT = 24576
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] Xbus,
  input  logic         mode,
  output logic         ready,
  output logic         done,
  output logic [W-1:0] Rbus
);
  localparam int AW = W + 2;
  localparam int PW = 2 * AW;
  localparam longint ONE_L = longint'(1) << FRAC;
  localparam longint C1 = -((2 * ONE_L + 3) / 6);
  localparam longint C2 = (4 * ONE_L + 15) / 30;
  localparam longint C3 = -((34 * ONE_L + 315) / 630);
  localparam longint C4 = (124 * ONE_L + 2835) / 5670;
  localparam logic signed [AW:0] ONEV = (AW+1)'(ONE_L);
  localparam logic signed [AW:0] TSAT = (AW+1)'(ONE_L - 1);
  localparam logic signed [AW:0] MAXV = (AW+1)'((longint'(1) << (W-1)) - 1);
  localparam logic signed [AW:0] MINV = (AW+1)'(-(longint'(1) << (W-1)));
  localparam logic [W:0] XS = (W+1)'(XSAT);
  typedef enum logic [2:0] {IDLE, SQR, HORN, MULX, FIN} state_t;
  state_t st, nx;
  logic signed [W-1:0] xs, xn, xe;
  logic [W:0] ax;
  logic md, sat;
  logic signed [AW-1:0] x2, acc, xw, mul_a, mul_b, mres;
  logic signed [PW-1:0] prod;
  logic signed [AW:0] tf, sg;
  logic [2:0] k;
  function automatic logic signed [AW-1:0] coef(input logic [2:0] i);
    return i == 3'd0 ? AW'(ONE_L) :
           i == 3'd1 ? AW'(C1) :
           i == 3'd2 ? AW'(C2) :
           i == 3'd3 ? AW'(C3) : AW'(C4);
  endfunction
  assign xs = $signed(Xbus);
  assign xn = mode ? xs >>> 1 : xs;
  assign ax = xn[W-1] ? -{xn[W-1], xn} : {xn[W-1], xn};
  assign xw = {{2{xe[W-1]}}, xe};
  assign mul_a = st == SQR ? xw : acc;
  assign mul_b = st == HORN ? x2 : xw;
  assign prod = mul_a * mul_b;
  assign mres = AW'(prod >>> FRAC);
  // most-negative Xbus saturates even when halving for sigmoid brings it under XSAT
  assign tf = sat ? (xe[W-1] ? -TSAT : TSAT) : {acc[AW-1], acc};
  assign sg = md ? (ONEV + tf) >>> 1 : tf;
  assign ready = st == IDLE;
  always_comb begin
    nx = st;
    case (st)
      IDLE: nx = start ? SQR : IDLE;
      SQR:  nx = TERMS > 1 ? HORN : MULX;
      HORN: nx = k == 3'd0 ? MULX : HORN;
      MULX: nx = FIN;
      default: nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) st <= IDLE;
    else st <= nx;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      xe <= '0;
      md <= 1'b0;
      sat <= 1'b0;
      x2 <= '0;
      acc <= '0;
      k <= '0;
      done <= 1'b0;
      Rbus <= '0;
    end else begin
      done <= st == FIN;
      case (st)
        IDLE: if (start) begin
          xe <= xn;
          md <= mode;
          sat <= (Xbus == {1'b1, {(W-1){1'b0}}}) || (ax >= XS);
        end
        SQR: begin
          x2 <= mres;
          acc <= coef(3'(TERMS - 1));
          k <= 3'(TERMS - 2);
        end
        HORN: begin
          acc <= coef(k) + mres;
          k <= k - 3'd1;
        end
        MULX: acc <= mres;
        FIN: Rbus <= sg > MAXV ? MAXV[W-1:0] : sg < MINV ? MINV[W-1:0] : sg[W-1:0];
        default: ;
      endcase
    end
endmodule

// File: tb/tb_tanh_series_unit.sv
// tb_tanh_series_unit: randomized and directed checks of three TERMS variants against an arithmetic model
module tb_tanh_series_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic mode = 1'b0;
  logic [15:0] xbus = '0;
  logic rdy [3];
  logic dn [3];
  logic [15:0] rb [3];
  int tl [3] = '{4, 1, 5};
  int nvec = 0;
  int nerr = 0;
  always #5 clk = ~clk;
  tanh_series_unit #(.TERMS(4)) d4 (.clk(clk), .rst(rst), .start(start), .Xbus(xbus), .mode(mode), .ready(rdy[0]), .done(dn[0]), .Rbus(rb[0]));
  tanh_series_unit #(.TERMS(1)) d1 (.clk(clk), .rst(rst), .start(start), .Xbus(xbus), .mode(mode), .ready(rdy[1]), .done(dn[1]), .Rbus(rb[1]));
  tanh_series_unit #(.TERMS(5)) d5 (.clk(clk), .rst(rst), .start(start), .Xbus(xbus), .mode(mode), .ready(rdy[2]), .done(dn[2]), .Rbus(rb[2]));
  task automatic check(input string tag, input int got, input int exp);
    nvec++;
    if (got != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  function automatic int model(input logic [15:0] xv, input bit m, input int terms);
    longint c [5] = '{16384, -5461, 2185, -884, 358};
    longint x = longint'($signed(xv));
    longint xe = m ? x >>> 1 : x;
    longint x2, acc, t;
    if (x == -32768 || xe >= 24576 || xe <= -24576) t = xe > 0 ? 16383 : -16383;
    else begin
      x2 = (xe * xe) >>> 14;
      acc = c[terms-1];
      for (int j = terms - 2; j >= 0; j--) acc = c[j] + ((acc * x2) >>> 14);
      t = (acc * xe) >>> 14;
    end
    if (m) t = (16384 + t) >>> 1;
    if (t > 32767) t = 32767;
    if (t < -32768) t = -32768;
    return int'(t);
  endfunction
  function automatic int sv(input logic [15:0] v);
    return int'($signed(v));
  endfunction
  task automatic op(input logic [15:0] xv, input bit m, input bit poke);
    int lat [3] = '{-1, -1, -1};
    @(negedge clk);
    xbus = xv;
    mode = m;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    xbus = 16'($urandom);
    mode = ~m;
    for (int n = 1; n <= 8; n++) begin
      if (poke && n == 2) begin
        start = 1'b1;
        xbus = 16'($urandom);
      end
      if (poke && n == 3) start = 1'b0;
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
        if (lat[i] >= 0 && n == lat[i] + 1) check($sformatf("done_low_t%0d", tl[i]), int'(dn[i]), 0);
        if (lat[i] < 0 && rdy[i]) begin
          lat[i] = n;
          check($sformatf("done_t%0d", tl[i]), int'(dn[i]), 1);
          check($sformatf("rbus_t%0d_x%h_m%0d", tl[i], xv, m), sv(rb[i]), model(xv, m, tl[i]));
        end
      end
    end
    for (int i = 0; i < 3; i++) check($sformatf("latency_t%0d", tl[i]), lat[i], tl[i] + 2);
  endtask
  initial begin
    logic [15:0] q [3][$];
    #2;
    for (int i = 0; i < 3; i++) begin
      check("reset_ready", int'(rdy[i]), 1);
      check("reset_done", int'(dn[i]), 0);
      check("reset_rbus", sv(rb[i]), 0);
    end
    @(negedge clk);
    rst = 1'b0;
    op(16'h2000, 1'b0, 1'b0);
    check("spec_half_t4", sv(rb[0]), 7570);
    check("spec_half_t1", sv(rb[1]), 8192);
    check("spec_half_t5", sv(rb[2]), 7571);
    op(16'hE000, 1'b0, 1'b0);
    check("spec_neghalf", sv(rb[0]), -7571);
    op(16'h0000, 1'b0, 1'b0);
    check("spec_zero_tanh", sv(rb[0]), 0);
    op(16'h0000, 1'b1, 1'b0);
    check("spec_zero_sig", sv(rb[0]), 8192);
    op(16'h4000, 1'b1, 1'b0);
    check("spec_sig_one", sv(rb[0]), 11977);
    op(16'h7000, 1'b0, 1'b0);
    check("spec_sat_pos", sv(rb[0]), 16383);
    op(16'h9000, 1'b0, 1'b0);
    check("spec_sat_neg", sv(rb[0]), -16383);
    op(16'h8000, 1'b0, 1'b0);
    check("spec_sat_min", sv(rb[0]), -16383);
    op(16'h8000, 1'b1, 1'b0);
    check("spec_sat_min_sig", sv(rb[0]), 0);
    op(16'h5FFF, 1'b0, 1'b0);
    op(16'h6000, 1'b0, 1'b0);
    check("sat_edge", sv(rb[0]), 16383);
    op(16'hA000, 1'b0, 1'b0);
    op(16'h2000, 1'b0, 1'b1);
    check("busy_ignored", sv(rb[0]), 7570);
    for (int r = 0; r < 25; r++) op(16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    @(negedge clk);
    xbus = 16'h4000;
    mode = 1'b0;
    start = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      check("async_rst_ready", int'(rdy[i]), 1);
      check("async_rst_done", int'(dn[i]), 0);
      check("async_rst_rbus", sv(rb[i]), 0);
    end
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    op(16'h2000, 1'b0, 1'b0);
    check("post_rst_half", sv(rb[0]), 7570);
    @(negedge clk);
    xbus = 16'hE000;
    mode = 1'b0;
    start = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 18; n++) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) if (dn[i]) q[i].push_back(16'(n));
    end
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("b2b_count_t%0d", tl[i]), q[i].size() >= 2 ? 1 : 0, 1);
      if (q[i].size() >= 2) begin
        check($sformatf("b2b_first_t%0d", tl[i]), int'(q[i][0]), tl[i] + 2);
        check($sformatf("b2b_second_t%0d", tl[i]), int'(q[i][1]), 2 * (tl[i] + 2) + 1);
      end
      check($sformatf("b2b_rbus_t%0d", tl[i]), sv(rb[i]), model(16'hE000, 1'b0, tl[i]));
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
